// File: rtl/trb_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// trb_mem_arbiter_pkg
// Shared definitions for the trace-buffer BRAM arbiter:
//   TRB_ADDR_WIDTH / TRB_WIDTH : default trace-buffer geometry
//   arb_state_t                : turn FSM states (IDLE, RD, WR)
//   arb_mode_t                 : fill policy (stream = block on full,
//                                ring = overwrite and flag overflow)
// -----------------------------------------------------------------------------
package trb_mem_arbiter_pkg;

  localparam int TRB_ADDR_WIDTH = 10;
  localparam int TRB_WIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_STREAM = 1'b0,
    ARB_RING   = 1'b1
  } arb_mode_t;

endpackage

// File: rtl/trb_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// trb_mem_arbiter_if
// Bundles every non-clock/reset signal of the arbiter.
//   Logger side : ENABLE_I, CLEAR_I, MODE_I, WRITE_I, WRITE_PTR_I, DATA_I,
//                 READ_I, READ_PTR_I -> arbiter
//                 RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O, DMEM_O, DMEM_VALID_O,
//                 LEVEL_O, OVERFLOW_O <- arbiter
//   BRAM side   : MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O <- arbiter
//                 MEM_DATA_I (1-cycle read latency) -> arbiter
// Modports: slave = the arbiter, master = the Logger/BRAM environment.
// -----------------------------------------------------------------------------
interface trb_mem_arbiter_if
  import trb_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int WIDTH      = TRB_WIDTH
) ();

  logic                  ENABLE_I;
  logic                  CLEAR_I;
  logic                  MODE_I;
  logic                  RW_TURN_O;
  logic                  WRITE_I;
  logic [ADDR_WIDTH-1:0] WRITE_PTR_I;
  logic [WIDTH-1:0]      DATA_I;
  logic                  READ_I;
  logic [ADDR_WIDTH-1:0] READ_PTR_I;
  logic                  WRITE_ALLOW_O;
  logic                  READ_ALLOW_O;
  logic [WIDTH-1:0]      DMEM_O;
  logic                  DMEM_VALID_O;
  logic [ADDR_WIDTH:0]   LEVEL_O;
  logic                  OVERFLOW_O;
  logic                  MEM_EN_O;
  logic                  MEM_WE_O;
  logic [ADDR_WIDTH-1:0] MEM_ADDR_O;
  logic [WIDTH-1:0]      MEM_DATA_O;
  logic [WIDTH-1:0]      MEM_DATA_I;

  modport slave (
    input  ENABLE_I, CLEAR_I, MODE_I, WRITE_I, WRITE_PTR_I, DATA_I,
           READ_I, READ_PTR_I, MEM_DATA_I,
    output RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O, DMEM_O, DMEM_VALID_O,
           LEVEL_O, OVERFLOW_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O
  );

  modport master (
    output ENABLE_I, CLEAR_I, MODE_I, WRITE_I, WRITE_PTR_I, DATA_I,
           READ_I, READ_PTR_I, MEM_DATA_I,
    input  RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O, DMEM_O, DMEM_VALID_O,
           LEVEL_O, OVERFLOW_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O
  );

endinterface

// File: rtl/trb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// trb_mem_arbiter
// Turn-based arbiter and fill-level tracker for the single-port trace-buffer
// BRAM behind the Logger. Alternates read and write turns, tells the Logger
// when each access may be taken, issues the accepted access to the BRAM in the
// same cycle and returns read data two cycles after issue with a strobe.
// Stream mode blocks writes when full; ring mode overwrites and sets a sticky
// overflow flag.
//
// Ports:
//   CLK_I  : clock
//   RST_I  : asynchronous active-high reset
//   bus    : trb_mem_arbiter_if.slave (Logger control/data + BRAM port)
// -----------------------------------------------------------------------------
module trb_mem_arbiter
  import trb_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int WIDTH      = TRB_WIDTH
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  trb_mem_arbiter_if.slave bus
);

  localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);

  arb_state_t          state_reg, state_next;
  logic                rw_turn_reg;
  logic                write_allow_reg;
  logic                read_allow_reg;
  logic [ADDR_WIDTH:0] level_reg, level_next;
  logic                overflow_reg, overflow_next;
  logic                rd_pend_reg;
  logic                dmem_valid_reg;
  logic [WIDTH-1:0]    dmem_reg;

  logic                write_acc;
  logic                read_acc;
  logic                ring_mode;

  // Turn sequencing: IDLE -> RD -> WR -> RD ... while enabled.
  always_comb begin
    state_next = state_reg;
    if (bus.CLEAR_I || !bus.ENABLE_I) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = RD;
        RD:      state_next = WR;
        WR:      state_next = RD;
        default: state_next = IDLE;
      endcase
    end
  end

  assign ring_mode = (arb_mode_t'(bus.MODE_I) == ARB_RING);

  // Accepts use the registered permissions only; the intents never feed back
  // into the ALLOW outputs. A clear cycle issues nothing, so a read started
  // in the clear cycle cannot produce a late strobe.
  assign write_acc = !bus.CLEAR_I && (state_reg == WR) && bus.WRITE_I && write_allow_reg;
  assign read_acc  = !bus.CLEAR_I && (state_reg == RD) && bus.READ_I  && read_allow_reg;

  // Reads and writes are on opposite turns, so at most one of them moves the
  // level in a given cycle.
  always_comb begin
    level_next    = level_reg;
    overflow_next = overflow_reg;
    if (bus.CLEAR_I) begin
      level_next    = '0;
      overflow_next = 1'b0;
    end else if (write_acc) begin
      if (level_reg != LEVEL_FULL) begin
        level_next = level_reg + LEVEL_ONE;
      end else begin
        // Only reachable in ring mode: the oldest word was overwritten.
        overflow_next = 1'b1;
      end
    end else if (read_acc) begin
      level_next = level_reg - LEVEL_ONE;
    end
  end

  // All state and all registered outputs. The permissions are computed from
  // the next state/level so that they are pure registers in the cycle they
  // apply to; MODE_I is sampled here, so a mode change shows one cycle later.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_reg       <= IDLE;
      rw_turn_reg     <= 1'b0;
      write_allow_reg <= 1'b0;
      read_allow_reg  <= 1'b0;
      level_reg       <= '0;
      overflow_reg    <= 1'b0;
      rd_pend_reg     <= 1'b0;
      dmem_valid_reg  <= 1'b0;
      dmem_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      rw_turn_reg     <= (state_next == WR);
      write_allow_reg <= (state_next != IDLE) && (ring_mode || (level_next != LEVEL_FULL));
      read_allow_reg  <= (state_next != IDLE) && (level_next != '0);
      level_reg       <= level_next;
      overflow_reg    <= overflow_next;
      // rd_pend_reg marks the cycle in which the BRAM presents the data; a
      // clear in that cycle discards it.
      rd_pend_reg     <= read_acc;
      dmem_valid_reg  <= rd_pend_reg && !bus.CLEAR_I;
      if (rd_pend_reg && !bus.CLEAR_I) begin
        dmem_reg <= bus.MEM_DATA_I;
      end
    end
  end

  assign bus.RW_TURN_O     = rw_turn_reg;
  assign bus.WRITE_ALLOW_O = write_allow_reg;
  assign bus.READ_ALLOW_O  = read_allow_reg;
  assign bus.LEVEL_O       = level_reg;
  assign bus.OVERFLOW_O    = overflow_reg;
  assign bus.DMEM_O        = dmem_reg;
  assign bus.DMEM_VALID_O  = dmem_valid_reg;

  // BRAM access is issued combinationally in the accept cycle.
  assign bus.MEM_EN_O   = write_acc || read_acc;
  assign bus.MEM_WE_O   = write_acc;
  assign bus.MEM_ADDR_O = write_acc ? bus.WRITE_PTR_I :
                          (read_acc ? bus.READ_PTR_I : '0);
  assign bus.MEM_DATA_O = write_acc ? bus.DATA_I : '0;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trb_mem_arbiter
// Bench for trb_mem_arbiter with DEPTH 4 / 8-bit words. Directed scenarios
// (reset, stream fill, readback, ring overflow, clear mid-read, enable drop)
// followed by a randomized run checked against a transaction-level model:
// turn parity from the count of enabled edges, an integer fill level, a
// shadow memory and a queue of reads with their due cycle.
// -----------------------------------------------------------------------------
module tb_trb_mem_arbiter;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  trb_mem_arbiter_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

  trb_mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  // External single-port BRAM with one cycle of read latency.
  logic [DW-1:0] bram [DEPTH] = '{default: 8'h00};
  logic [DW-1:0] bram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.MEM_EN_O) begin
      if (bus.MEM_WE_O) bram[bus.MEM_ADDR_O] <= bus.MEM_DATA_O;
      else              bram_q <= bram[bus.MEM_ADDR_O];
    end
  end
  assign bus.MEM_DATA_I = bram_q;

  wire [27:0] all_outs = {bus.RW_TURN_O, bus.WRITE_ALLOW_O, bus.READ_ALLOW_O,
                          bus.DMEM_VALID_O, bus.DMEM_O, bus.LEVEL_O, bus.OVERFLOW_O,
                          bus.MEM_EN_O, bus.MEM_WE_O, bus.MEM_ADDR_O, bus.MEM_DATA_O};

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  int            k;        // consecutive enabled edges since idle
  int            mc = 0;   // model cycle number
  int            m_level;
  bit            m_ovf;
  bit            m_mode;
  logic [DW-1:0] m_dmem;
  logic [DW-1:0] shadow [DEPTH] = '{default: 8'h00};
  rd_t           rdq [$];

  bit            e_turn, e_wallow, e_rallow, e_wacc, e_racc, e_valid;
  logic [DW-1:0] e_dmem;

  task automatic model_reset();
    k = 0; m_level = 0; m_ovf = 0; m_mode = 0; m_dmem = '0;
    rdq.delete();
  endtask

  task automatic model_eval();
    e_turn   = (k != 0) && (k % 2 == 0);
    e_wallow = (k != 0) && (m_mode || m_level != DEPTH);
    e_rallow = (k != 0) && (m_level != 0);
    e_wacc   = !bus.CLEAR_I && e_turn && bus.WRITE_I && e_wallow;
    e_racc   = !bus.CLEAR_I && (k != 0) && !e_turn && bus.READ_I && e_rallow;
    e_valid  = (rdq.size() > 0) && (rdq[0].due == mc);
    e_dmem   = e_valid ? rdq[0].d : m_dmem;
  endtask

  task automatic model_advance();
    if (e_valid) begin
      m_dmem = rdq[0].d;
      void'(rdq.pop_front());
    end
    if (bus.CLEAR_I) begin
      m_level = 0; m_ovf = 0; k = 0;
      rdq.delete();
    end else begin
      if (e_wacc) begin
        shadow[bus.WRITE_PTR_I] = bus.DATA_I;
        if (m_level < DEPTH) m_level++;
        else                 m_ovf = 1;
      end
      if (e_racc) begin
        rdq.push_back('{due: mc + 2, d: shadow[bus.READ_PTR_I]});
        m_level--;
      end
      k = bus.ENABLE_I ? k + 1 : 0;
    end
    m_mode = bus.MODE_I;
    mc++;
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input bit en, input bit clr, input bit mode, input bit w,
                        input logic [AW-1:0] wp, input logic [DW-1:0] d,
                        input bit r, input logic [AW-1:0] rp);
    bus.ENABLE_I    = en;
    bus.CLEAR_I     = clr;
    bus.MODE_I      = mode;
    bus.WRITE_I     = w;
    bus.WRITE_PTR_I = wp;
    bus.DATA_I      = d;
    bus.READ_I      = r;
    bus.READ_PTR_I  = rp;
  endtask

  // Called with inputs already applied (mid-cycle): advance model, cross edge.
  task automatic tick();
    model_eval();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nw = 0;
    set_in(0, 0, 0, 0, '0, '0, 0, '0);
    #1 rst = 1'b1;
    #2;
    n_tests++;
    if (all_outs !== 28'h0) begin
      n_fail++; $display("FAIL reset_initial: outputs %h, required 0", all_outs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 20 && nw < 3; c++) begin
      set_in(1, 0, 0, 1, AW'(nw), 8'(8'h30 + nw), 0, '0);
      #1;
      if (bus.MEM_EN_O && bus.MEM_WE_O) begin
        $display("[TB] reset_fill write ptr %0d data %h", nw, bus.MEM_DATA_O);
        nw++;
      end
      tick();
    end
    set_in(1, 0, 0, 0, '0, '0, 0, '0);
    n_tests++;
    if (bus.LEVEL_O !== 3'd3) begin
      n_fail++; $display("FAIL reset_prefill_level: got %0d, required 3", bus.LEVEL_O);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (all_outs !== 28'h0) begin
      n_fail++; $display("FAIL reset_midrun: outputs %h, required 0", all_outs);
    end
    @(posedge clk); #1;
    n_tests++;
    if (all_outs !== 28'h0) begin
      n_fail++; $display("FAIL reset_held: outputs %h, required 0", all_outs);
    end
    set_in(0, 0, 0, 0, '0, '0, 0, '0);
    rst = 1'b0;
    model_reset();
    $display("[TB] reset done");
  endtask

  logic [DW-1:0] tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic test_stream_fill();
    int nw = 0;
    for (int c = 0; c < 14; c++) begin
      set_in(1, 0, 0, 1, AW'(nw), (nw < 4) ? tbl[nw] : 8'hEE, 0, '0);
      #1;
      if (bus.MEM_EN_O && bus.MEM_WE_O) begin
        n_tests++;
        if (nw >= 4 || bus.MEM_ADDR_O !== AW'(nw) || bus.MEM_DATA_O !== tbl[nw]) begin
          n_fail++;
          $display("FAIL stream_write #%0d: addr %0d data %h, required addr %0d data from table",
                   nw, bus.MEM_ADDR_O, bus.MEM_DATA_O, nw);
        end
        $display("[TB] stream write ptr %0d data %h", bus.MEM_ADDR_O, bus.MEM_DATA_O);
        nw++;
      end
      tick();
    end
    set_in(1, 0, 0, 0, '0, '0, 0, '0);
    n_tests++;
    if (nw != 4) begin n_fail++; $display("FAIL stream_count: got %0d writes, required 4", nw); end
    n_tests++;
    if (bus.LEVEL_O !== 3'd4) begin n_fail++; $display("FAIL stream_level: got %0d, required 4", bus.LEVEL_O); end
    n_tests++;
    if (bus.WRITE_ALLOW_O !== 1'b0) begin n_fail++; $display("FAIL stream_wallow: got %b, required 0", bus.WRITE_ALLOW_O); end
    n_tests++;
    if (bus.OVERFLOW_O !== 1'b0) begin n_fail++; $display("FAIL stream_ovf: got %b, required 0", bus.OVERFLOW_O); end
  endtask

  task automatic test_readback();
    int nr = 0;
    int nd = 0;
    int issue_cyc [4];
    for (int c = 0; c < 18; c++) begin
      set_in(1, 0, 0, 0, '0, '0, nr < 4, AW'(nr));
      #1;
      if (bus.MEM_EN_O && !bus.MEM_WE_O) begin
        if (nr < 4) issue_cyc[nr] = cyc;
        nr++;
      end
      if (bus.DMEM_VALID_O) begin
        n_tests++;
        if (nd >= 4) begin
          n_fail++; $display("FAIL readback_extra: unexpected strobe data %h", bus.DMEM_O);
        end else if (bus.DMEM_O !== tbl[nd] || cyc != issue_cyc[nd] + 2) begin
          n_fail++;
          $display("FAIL readback_%0d: data %h at +%0d cycles, required %h at +2",
                   nd, bus.DMEM_O, cyc - issue_cyc[nd], tbl[nd]);
        end
        $display("[TB] readback %0d data %h", nd, bus.DMEM_O);
        nd++;
      end
      tick();
    end
    n_tests++;
    if (nr != 4 || nd != 4) begin n_fail++; $display("FAIL readback_count: issued %0d returned %0d, required 4/4", nr, nd); end
    n_tests++;
    if (bus.LEVEL_O !== 3'd0) begin n_fail++; $display("FAIL readback_level: got %0d, required 0", bus.LEVEL_O); end
    n_tests++;
    if (bus.READ_ALLOW_O !== 1'b0) begin n_fail++; $display("FAIL readback_rallow: got %b, required 0", bus.READ_ALLOW_O); end
  endtask

  task automatic test_ring_overflow();
    int nw = 0;
    set_in(1, 1, 1, 0, '0, '0, 0, '0);
    #1;
    tick();
    n_tests++;
    if (bus.LEVEL_O !== 3'd0 || bus.OVERFLOW_O !== 1'b0) begin
      n_fail++; $display("FAIL ring_clear: level %0d ovf %b, required 0/0", bus.LEVEL_O, bus.OVERFLOW_O);
    end
    for (int c = 0; c < 20; c++) begin
      set_in(1, 0, 1, nw < 6, AW'(nw), 8'(8'hA0 + nw), 0, '0);
      #1;
      n_tests++;
      if (bus.OVERFLOW_O !== (nw >= 5)) begin
        n_fail++; $display("FAIL ring_ovf after %0d writes: got %b, required %b", nw, bus.OVERFLOW_O, nw >= 5);
      end
      if (nw >= 1) begin
        n_tests++;
        if (bus.WRITE_ALLOW_O !== 1'b1) begin
          n_fail++; $display("FAIL ring_wallow after %0d writes: got %b, required 1", nw, bus.WRITE_ALLOW_O);
        end
      end
      if (bus.MEM_EN_O && bus.MEM_WE_O) begin
        $display("[TB] ring write ptr %0d data %h", bus.MEM_ADDR_O, bus.MEM_DATA_O);
        nw++;
      end
      tick();
    end
    set_in(1, 0, 1, 0, '0, '0, 0, '0);
    n_tests++;
    if (nw != 6) begin n_fail++; $display("FAIL ring_count: got %0d writes, required 6", nw); end
    n_tests++;
    if (bus.LEVEL_O !== 3'd4) begin n_fail++; $display("FAIL ring_level: got %0d, required 4", bus.LEVEL_O); end
    n_tests++;
    if (bus.OVERFLOW_O !== 1'b1) begin n_fail++; $display("FAIL ring_ovf_final: got %b, required 1", bus.OVERFLOW_O); end
  endtask

  task automatic test_clear_mid_read();
    bit found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      set_in(1, 0, 1, 0, '0, '0, 1, 2'd1);
      #1;
      if (bus.MEM_EN_O && !bus.MEM_WE_O) begin
        found = 1;
        $display("[TB] clear_mid_read read issued ptr %0d", bus.MEM_ADDR_O);
      end
      tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL clear_read_issue: no read within 8 cycles, required one");
    end else begin
      set_in(1, 1, 1, 0, '0, '0, 0, '0);
      #1;
      tick();
      n_tests++;
      if (bus.DMEM_VALID_O !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b, required 0", bus.DMEM_VALID_O); end
      n_tests++;
      if (bus.LEVEL_O !== 3'd0 || bus.OVERFLOW_O !== 1'b0) begin
        n_fail++; $display("FAIL clear_level_ovf: level %0d ovf %b, required 0/0", bus.LEVEL_O, bus.OVERFLOW_O);
      end
      n_tests++;
      if ({bus.RW_TURN_O, bus.WRITE_ALLOW_O, bus.READ_ALLOW_O} !== 3'b000) begin
        n_fail++; $display("FAIL clear_idle: turn/wallow/rallow %b%b%b, required 000",
                           bus.RW_TURN_O, bus.WRITE_ALLOW_O, bus.READ_ALLOW_O);
      end
      set_in(0, 0, 0, 0, '0, '0, 0, '0);
      #1;
      tick();
      n_tests++;
      if (bus.DMEM_VALID_O !== 1'b0) begin n_fail++; $display("FAIL clear_valid_late: got %b, required 0", bus.DMEM_VALID_O); end
    end
  endtask

  task automatic test_enable_drop();
    bit found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (bus.RW_TURN_O === 1'b1) begin
        found = 1;
        set_in(0, 0, 0, 1, 2'd2, 8'h5A, 0, '0);
        #1;
        n_tests++;
        if ({bus.MEM_EN_O, bus.MEM_WE_O, bus.MEM_ADDR_O, bus.MEM_DATA_O} !== {1'b1, 1'b1, 2'd2, 8'h5A}) begin
          n_fail++; $display("FAIL drop_write: en %b we %b addr %0d data %h, required 1 1 2 5a",
                             bus.MEM_EN_O, bus.MEM_WE_O, bus.MEM_ADDR_O, bus.MEM_DATA_O);
        end
        $display("[TB] enable_drop write ptr %0d data %h", bus.MEM_ADDR_O, bus.MEM_DATA_O);
        tick();
        n_tests++;
        if (bus.RW_TURN_O !== 1'b0 || bus.MEM_EN_O !== 1'b0 || bus.WRITE_ALLOW_O !== 1'b0) begin
          n_fail++; $display("FAIL drop_idle: turn %b mem_en %b wallow %b, required 0 0 0",
                             bus.RW_TURN_O, bus.MEM_EN_O, bus.WRITE_ALLOW_O);
        end
        n_tests++;
        if (bus.LEVEL_O !== 3'd1) begin n_fail++; $display("FAIL drop_level: got %0d, required 1", bus.LEVEL_O); end
        tick();
        n_tests++;
        if (bus.LEVEL_O !== 3'd1) begin n_fail++; $display("FAIL drop_level_hold: got %0d, required 1", bus.LEVEL_O); end
      end else begin
        set_in(1, 0, 0, 1, 2'd2, 8'h5A, 0, '0);
        #1;
        tick();
      end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL drop_turn: no write turn within 8 cycles, required one"); end
    set_in(0, 0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic test_random();
    bit rmode = 0;
    set_in(0, 0, 0, 0, '0, '0, 0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom % 25 == 0) rmode = ~rmode;
      set_in(($urandom % 8) != 0, ($urandom % 40) == 0, rmode, 1'($urandom),
             AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom));
      #1;
      model_eval();
      n_tests++;
      if (bus.RW_TURN_O !== e_turn) begin n_fail++; $display("FAIL rnd_turn c%0d: got %b, required %b", c, bus.RW_TURN_O, e_turn); end
      n_tests++;
      if (bus.WRITE_ALLOW_O !== e_wallow) begin n_fail++; $display("FAIL rnd_wallow c%0d: got %b, required %b", c, bus.WRITE_ALLOW_O, e_wallow); end
      n_tests++;
      if (bus.READ_ALLOW_O !== e_rallow) begin n_fail++; $display("FAIL rnd_rallow c%0d: got %b, required %b", c, bus.READ_ALLOW_O, e_rallow); end
      n_tests++;
      if (bus.MEM_EN_O !== (e_wacc || e_racc) || bus.MEM_WE_O !== e_wacc) begin
        n_fail++; $display("FAIL rnd_mem_en c%0d: en %b we %b, required %b %b", c, bus.MEM_EN_O, bus.MEM_WE_O, e_wacc || e_racc, e_wacc);
      end
      if (e_wacc) begin
        n_tests++;
        if (bus.MEM_ADDR_O !== bus.WRITE_PTR_I || bus.MEM_DATA_O !== bus.DATA_I) begin
          n_fail++; $display("FAIL rnd_wr_bus c%0d: addr %0d data %h, required %0d %h", c, bus.MEM_ADDR_O, bus.MEM_DATA_O, bus.WRITE_PTR_I, bus.DATA_I);
        end
        $display("[TB] rnd c%0d WR ptr %0d data %h level %0d", c, bus.WRITE_PTR_I, bus.DATA_I, m_level);
      end
      if (e_racc) begin
        n_tests++;
        if (bus.MEM_ADDR_O !== bus.READ_PTR_I) begin
          n_fail++; $display("FAIL rnd_rd_addr c%0d: got %0d, required %0d", c, bus.MEM_ADDR_O, bus.READ_PTR_I);
        end
        $display("[TB] rnd c%0d RD ptr %0d level %0d", c, bus.READ_PTR_I, m_level);
      end
      n_tests++;
      if (bus.LEVEL_O !== 3'(m_level)) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d, required %0d", c, bus.LEVEL_O, m_level); end
      n_tests++;
      if (bus.OVERFLOW_O !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b, required %b", c, bus.OVERFLOW_O, m_ovf); end
      n_tests++;
      if (bus.DMEM_VALID_O !== e_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b, required %b", c, bus.DMEM_VALID_O, e_valid); end
      if (e_valid) begin
        n_tests++;
        if (bus.DMEM_O !== e_dmem) begin n_fail++; $display("FAIL rnd_dmem c%0d: got %h, required %h", c, bus.DMEM_O, e_dmem); end
        $display("[TB] rnd c%0d DMEM %h", c, bus.DMEM_O);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream_fill();
    test_readback();
    test_ring_overflow();
    test_clear_mid_read();
    test_enable_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trb_mem_arbiter.md
# trb_mem_arbiter

Turn-based arbiter and fill-level tracker for the single-port trace-buffer BRAM behind the Logger. It generates the read/write turn strobe and the write/read permissions the Logger consumes. It issues the Logger's accesses to the BRAM on the correct turn and returns read data with a valid strobe. Stream mode blocks writes on full; trace (ring) mode overwrites and flags overflow.

## Interface
Parameters:
- ADDR_WIDTH, default TRB_ADDR_WIDTH: BRAM address width; DEPTH = 2**ADDR_WIDTH.
- WIDTH, default TRB_WIDTH: BRAM word width.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset, asynchronous, active-high.
- ENABLE_I  in  1  arbitration running.
- CLEAR_I  in  1  synchronous clear of level, overflow and pending read.
- MODE_I  in  1  0 = stream (no overwrite), 1 = ring (overwrite).
- RW_TURN_O  out  1  1 = write turn, 0 = read turn.
- WRITE_I  in  1  Logger write intent.
- WRITE_PTR_I  in  ADDR_WIDTH  Logger write pointer.
- DATA_I  in  WIDTH  write data.
- READ_I  in  1  Logger read intent.
- READ_PTR_I  in  ADDR_WIDTH  Logger read pointer.
- WRITE_ALLOW_O  out  1  write may be accepted.
- READ_ALLOW_O  out  1  read may be accepted.
- DMEM_O  out  WIDTH  read data.
- DMEM_VALID_O  out  1  one-cycle strobe, DMEM_O valid.
- LEVEL_O  out  ADDR_WIDTH+1  stored word count, 0..DEPTH.
- OVERFLOW_O  out  1  sticky; ring-mode overwrite occurred.
- MEM_EN_O, MEM_WE_O  out  1  BRAM enable / write enable.
- MEM_ADDR_O  out  ADDR_WIDTH  BRAM address.
- MEM_DATA_O  out  WIDTH  BRAM write data.
- MEM_DATA_I  in  WIDTH  BRAM read data, 1-cycle latency.

## Operation
- FSM states: IDLE, RD, WR. It is a registered Moore machine; RW_TURN_O = (state == WR).
- Transitions:
  - IDLE→RD when ENABLE_I=1.
  - RD→WR and WR→RD while ENABLE_I=1.
  - Any state→IDLE when ENABLE_I=0 or CLEAR_I=1.
- Permissions are decoded from registered state only, with no path from WRITE_I/READ_I:
  - WRITE_ALLOW_O = (state != IDLE) && (MODE_I || LEVEL != DEPTH).
  - READ_ALLOW_O = (state != IDLE) && (LEVEL != 0).
- Write accept:
  - Condition: state WR, WRITE_I=1 and WRITE_ALLOW_O=1.
  - Same cycle: MEM_EN_O=1, MEM_WE_O=1, MEM_ADDR_O=WRITE_PTR_I, MEM_DATA_O=DATA_I.
  - LEVEL increments if below DEPTH. Otherwise (ring mode, full) LEVEL holds and OVERFLOW_O is set.
- Read accept:
  - Condition: state RD, READ_I=1 and READ_ALLOW_O=1.
  - Same cycle: MEM_EN_O=1, MEM_WE_O=0, MEM_ADDR_O=READ_PTR_I. LEVEL decrements.
- Intents on the wrong turn are ignored. The Logger holds them until its turn.
- Reads and writes never share a cycle, so LEVEL never sees a simultaneous increment and decrement.
- Pointers are owned by the Logger. The arbiter passes them through and does not check them.
- CLEAR_I has priority over everything except RST_I. It sets LEVEL=0 and OVERFLOW_O=0, drops any in-flight read's DMEM_VALID_O, and moves the FSM to IDLE.
- When ENABLE_I falls, an already-issued read still completes with DMEM_VALID_O. LEVEL and OVERFLOW_O hold.
- MODE_I changes take effect on the next cycle's permission decode. Changing it while LEVEL=DEPTH is legal.

## Timing
- Reset values: state IDLE, RW_TURN_O=0, both ALLOWs 0, DMEM_VALID_O=0, DMEM_O=0, LEVEL_O=0, OVERFLOW_O=0, all MEM_* outputs 0.
- Enable latency: ENABLE_I sampled high at edge t gives state RD (RW_TURN_O=0) in cycle t+1 and WR in t+2, then alternation.
- Write latency: the MEM write is issued combinationally in the accept cycle. LEVEL_O updates at the next edge.
- Read latency: issued in cycle t, MEM_DATA_I valid in t+1, registered into DMEM_O with DMEM_VALID_O=1 in t+2.
- Maximum throughput: one write and one read per two cycles.
- OVERFLOW_O is visible the cycle after the overwriting write.

## Structure
- DTB_PKG gains:
  - arb_state_t enum {IDLE, RD, WR}.
  - arb_mode_t {ARB_STREAM=0, ARB_RING=1}.
  - TRB_ADDR_WIDTH and TRB_WIDTH remain there.
- Single module with no sub-module. The BRAM is external and instantiated by the parent beside the TraceLogger.

## Test plan
Use ADDR_WIDTH=2 (DEPTH 4) and WIDTH=8 for all scenarios.
- Reset: assert RST_I mid-run with LEVEL=3 → all outputs 0 immediately, state IDLE.
- Stream fill: MODE 0, WRITE_I held, data 0x11,0x22,0x33,0x44 at pointers 0..3 → four WR-turn writes, LEVEL 4, WRITE_ALLOW_O=0, fifth write not issued, OVERFLOW_O=0.
- Readback: READ_I held, pointers 0..3 → reads on RD turns; DMEM_O = 0x11..0x44, each strobed 2 cycles after issue; LEVEL 0, READ_ALLOW_O=0.
- Ring overflow: MODE 1, six writes → LEVEL saturates at 4, OVERFLOW_O=1 after the fifth write, WRITE_ALLOW_O stays 1.
- Clear mid-read: read issued at t, CLEAR_I at t+1 → no DMEM_VALID_O at t+2, LEVEL 0, OVERFLOW_O 0, state IDLE.
- Enable drop in WR with WRITE_I high → write that cycle issued, next cycle IDLE, RW_TURN_O=0, MEM_EN_O=0, LEVEL held.
